// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_STABLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  // Counter must be able to represent STABLE_CYCLES without wrapping.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer, stability counter, level register and
// registered rise/fall pulses. 'accept' is the combinational acceptance strobe.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic INIT_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int            CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q;
  logic                   differ;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign differ = (sync != level);
  assign accept = differ && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      level <= INIT_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!differ) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= '0;
        level <= sync;
        rise  <= sync;
        fall  <= ~sync;
      end else if (cnt_q < LAST) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debouncer_multi.sv
// N_CH independent debounce channels; any_change is registered from the
// channels' acceptance strobes so it lines up with the rise/fall pulses.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int              N_CH          = DEF_N_CH,
  parameter int              STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int              SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter logic [N_CH-1:0] INIT_VAL      = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] signal_in,
  output logic [N_CH-1:0] signal_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);

  logic [N_CH-1:0] accept;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .INIT_BIT      (INIT_VAL[g])
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (signal_in[g]),
      .level  (signal_out[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .accept (accept[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept;
    end
  end

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter STABLE_CYCLES, default 8: consecutive synchronized cycles a new level must hold before it is accepted (1..65535).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (2..4).
REQ-004 SHALL have parameter INIT_VAL, default {N_CH{1'b0}}: per-channel reset level of the synchronizer and of the debounced output.
REQ-005 SHALL have port clk, input, 1: single rising-edge clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port signal_in, input, N_CH: raw asynchronous bouncing inputs.
REQ-008 SHALL have port signal_out, output, N_CH: debounced levels, registered.
REQ-009 SHALL have port rise, output, N_CH: one-cycle pulse when signal_out[i] goes 0->1.
REQ-010 SHALL have port fall, output, N_CH: one-cycle pulse when signal_out[i] goes 1->0.
REQ-011 SHALL have port any_change, output, 1: OR of all rise and fall bits, registered in the same cycle.

Function
REQ-012 Each channel SHALL pass signal_in[i] through a SYNC_STAGES-deep flop chain; only the last stage (sync[i]) feeds the debounce logic.
REQ-013 Each channel SHALL hold a counter of width $clog2(STABLE_CYCLES+1) bits that saturates and never wraps.
REQ-014 While sync[i] == signal_out[i], the counter SHALL clear to 0 on every edge.
REQ-015 While sync[i] != signal_out[i] and the counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When sync[i] != signal_out[i] and the counter == STABLE_CYCLES-1, then on that edge signal_out[i] SHALL take sync[i], the counter SHALL clear, and rise[i] or fall[i] SHALL assert for exactly that one cycle.
REQ-017 Latency SHALL be exactly SYNC_STAGES+STABLE_CYCLES rising edges from the first edge that samples a new, held input level to the edge that updates signal_out.
REQ-018 Any return of sync[i] to signal_out[i] before acceptance (a glitch shorter than STABLE_CYCLES) SHALL clear the counter, leave signal_out unchanged and produce no pulse.
REQ-019 For STABLE_CYCLES=1, signal_out SHALL follow sync with a 1-cycle register delay, and every sync change SHALL pulse.
REQ-020 rise[i] and fall[i] SHALL never assert together, and a channel SHALL produce at most one pulse per STABLE_CYCLES cycles.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL pulse in the same cycle, with one any_change pulse.

Reset
REQ-022 On rst_n low, regardless of clk: sync stages and signal_out SHALL load INIT_VAL, counters 0, and rise/fall/any_change 0.
REQ-023 Reset asserted mid-count SHALL discard the partial count; after release, a differing input SHALL need the full SYNC_STAGES+STABLE_CYCLES again.
REQ-024 The first edge after rst_n release SHALL produce no pulse, even if signal_in differs from INIT_VAL.

Structure
REQ-025 Parameter defaults and the counter-width function SHALL live in shared package debounce_pkg.
REQ-026 Per-channel logic (synchronizer, counter, level register, edge pulses) SHALL be sub-module debounce_ch, instantiated N_CH times by a generate loop; the top holds only the any_change register.

Verification (N_CH=4, STABLE_CYCLES=8, SYNC_STAGES=2, INIT_VAL=0)
REQ-027 Clean step: signal_in[0] 0->1 and held -> signal_out[0]=1 and rise[0]=1 for one cycle exactly 10 edges later; any_change pulses the same cycle.
REQ-028 Bounce: signal_in[1] toggles high 5 cycles, low 2 cycles, then high and held -> no pulse during the bounce; rise[1] 10 edges after the final rising sample.
REQ-029 Glitch rejection: signal_in[2] high for 7 cycles then low -> signal_out[2] stays 0; no rise/fall/any_change.
REQ-030 Simultaneous: signal_in = 4'b1111 held from 4'b0000 -> rise = 4'b1111 in one cycle and a single any_change pulse; then 4'b0000 -> fall = 4'b1111 10 edges later.
REQ-031 Reset mid-count: signal_in[3] high, rst_n low after 6 edges for 3 cycles, then released -> signal_out[3]=0 during reset; rise[3] exactly 10 edges after release.
REQ-032 Boundary STABLE_CYCLES=1: single-cycle input pulse wider than one clock -> signal_out follows with 3-edge latency; rise and fall each pulse once.
